// File: rtl/rr_pkg.sv
// Shared definitions for the round-robin request agent and its arbiter:
// FSM state encoding, service-counter width and a one-hot test.
package rr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_ACK   = 2'd2
  } rr_state_t;

  localparam int unsigned SVC_W        = 8;
  localparam int unsigned ONEHOT_MAX_W = 32;

  // True when exactly one bit of vec is set (callers zero-extend narrower vectors).
  function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] vec);
    return (vec != 32'd0) && ((vec & (vec - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/rr_pending_counter.sv
// Saturating up/down pending-request counter for one client.
// A simultaneous push and dec nets to zero change and never reports overflow.
module rr_pending_counter
#(
  parameter int CNT_W = 3
)(
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             full,
  output logic             ovf_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;

  // Next-count and overflow-pulse decode.
  always_comb begin
    count_next_s = count_r;
    ovf_pulse    = 1'b0;
    if (push && !dec) begin
      if (count_r == CNT_MAX) begin
        ovf_pulse = 1'b1;
      end else begin
        count_next_s = count_r + CNT_ONE;
      end
    end else if (dec && !push) begin
      count_next_s = count_r - CNT_ONE;
    end else begin
      count_next_s = count_r;
    end
  end

  // Count register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_r <= CNT_ZERO;
    end else begin
      count_r <= count_next_s;
    end
  end

  assign count   = count_r;
  assign nonzero = (count_r != CNT_ZERO);
  assign full    = (count_r == CNT_MAX);

endmodule

// File: rtl/rr_request_agent.sv
// Requester-side agent: per-client pending counters, grant capture, fixed
// service window and one-cycle ack. Optional RR_GRANT_CHECK_EN adds grant_err.
module rr_request_agent
  import rr_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int CNT_W       = 3,
  parameter int SERVICE_LEN = 2
)(
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] push,
  output logic [WIDTH-1:0] req,
  input  logic [WIDTH-1:0] grant,
  output logic             ack,
  output logic [WIDTH-1:0] served,
  output logic [WIDTH-1:0] full,
  output logic             overflow,
`ifdef RR_GRANT_CHECK_EN
  output logic             grant_err,
`endif
  output logic             busy
);

  localparam logic [WIDTH-1:0] VEC_ZERO = {WIDTH{1'b0}};
  localparam logic [SVC_W-1:0] SVC_ZERO = {SVC_W{1'b0}};
  localparam logic [SVC_W-1:0] SVC_ONE  = {{(SVC_W-1){1'b0}}, 1'b1};
  localparam logic [SVC_W-1:0] SVC_LOAD = SVC_W'(SERVICE_LEN - 1);

  rr_state_t        state_r, state_next_s;
  logic [SVC_W-1:0] svc_r, svc_next_s;
  logic [WIDTH-1:0] grant_r, grant_next_s;
  logic             ack_r, ack_next_s;
  logic [WIDTH-1:0] served_r, served_next_s;
  logic             overflow_r;
  logic [WIDTH-1:0] dec_s, nonzero_s, full_s, ovf_s;
  logic [CNT_W-1:0] count_s [WIDTH];
  logic             grant_legal_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cnt
    // Decrement only a client that really has something pending.
    assign dec_s[i] = (state_r == ST_ACK) && grant_r[i] && (count_s[i] != {CNT_W{1'b0}});
    rr_pending_counter #(.CNT_W(CNT_W)) u_cnt (
      .clock     (clock),
      .reset     (reset),
      .push      (push[i]),
      .dec       (dec_s[i]),
      .count     (count_s[i]),
      .nonzero   (nonzero_s[i]),
      .full      (full_s[i]),
      .ovf_pulse (ovf_s[i])
    );
  end

  assign grant_legal_s = is_onehot(ONEHOT_MAX_W'(grant)) && ((grant & nonzero_s) != VEC_ZERO);

  // FSM next-state, service counter and ack/served decode.
  always_comb begin
    state_next_s = state_r;
    svc_next_s   = svc_r;
    grant_next_s = grant_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_legal_s) begin
          grant_next_s = grant;
          svc_next_s   = SVC_LOAD;
          state_next_s = ST_SERVE;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (svc_r == SVC_ZERO) begin
          state_next_s = ST_ACK;
        end else begin
          svc_next_s = svc_r - SVC_ONE;
        end
      end
      ST_ACK: begin
        state_next_s = ST_IDLE;
        grant_next_s = VEC_ZERO;
      end
      default: begin
        state_next_s = ST_IDLE;
        svc_next_s   = SVC_ZERO;
        grant_next_s = VEC_ZERO;
      end
    endcase
    ack_next_s    = (state_next_s == ST_ACK);
    served_next_s = ack_next_s ? grant_next_s : VEC_ZERO;
  end

  // FSM, captured grant, registered ack/served and sticky overflow.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      svc_r      <= SVC_ZERO;
      grant_r    <= VEC_ZERO;
      ack_r      <= 1'b0;
      served_r   <= VEC_ZERO;
      overflow_r <= 1'b0;
    end else begin
      state_r    <= state_next_s;
      svc_r      <= svc_next_s;
      grant_r    <= grant_next_s;
      ack_r      <= ack_next_s;
      served_r   <= served_next_s;
      overflow_r <= overflow_r | (ovf_s != VEC_ZERO);
    end
  end

`ifdef RR_GRANT_CHECK_EN
  logic grant_err_r;

  // One-cycle flag for a non-zero grant that IDLE refuses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant_err_r <= 1'b0;
    end else begin
      grant_err_r <= (state_r == ST_IDLE) && (grant != VEC_ZERO) && !grant_legal_s;
    end
  end

  assign grant_err = grant_err_r;
`endif

  assign req      = nonzero_s;
  assign full     = full_s;
  assign ack      = ack_r;
  assign served   = served_r;
  assign overflow = overflow_r;
  assign busy     = (state_r == ST_SERVE) || (state_r == ST_ACK);

endmodule

// File: tb/tb_rr_request_agent.sv
// Scoreboard bench for rr_request_agent: expected served/ack-cycle pairs are
// queued at grant time and popped by a negedge monitor on each ack.
module tb_rr_request_agent;

  localparam int WIDTH       = 4;
  localparam int CNT_W       = 3;
  localparam int SERVICE_LEN = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] push  = 4'b0000;
  logic [WIDTH-1:0] grant = 4'b0000;
  logic [WIDTH-1:0] req, served, full;
  logic             ack, overflow, busy;
`ifdef RR_GRANT_CHECK_EN
  logic             grant_err;
`endif

  rr_request_agent #(.WIDTH(WIDTH), .CNT_W(CNT_W), .SERVICE_LEN(SERVICE_LEN)) dut (
    .clock    (clock),
    .reset    (reset),
    .push     (push),
    .req      (req),
    .grant    (grant),
    .ack      (ack),
    .served   (served),
    .full     (full),
    .overflow (overflow),
`ifdef RR_GRANT_CHECK_EN
    .grant_err(grant_err),
`endif
    .busy     (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [WIDTH-1:0] served;
    int               cyc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack pops the scoreboard and checks client and timing.
  always @(negedge clock) begin
    if (reset === 1'b1 && ack === 1'b1) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ack: got ack served=%0h expected no ack (cycle %0d)", served, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("served", 32'(served), 32'(e.served));
        check("ack_cycle", cyc, e.cyc);
      end
    end else if (reset === 1'b1 && served !== 4'b0000) begin
      tests++;
      fails++;
      $display("FAIL stray_served: got %0h expected 0 (cycle %0d)", served, cyc);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ack();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (ack === 1'b1) got = 1'b1;
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
  endtask

  // Legal grant held until ack; optionally push the same client during ACK.
  task automatic serve(input logic [WIDTH-1:0] g, input bit push_in_ack);
    exp_t e;
    grant    = g;
    e.served = g;
    e.cyc    = cyc + 1 + SERVICE_LEN;
    sb.push_back(e);
    tick();
    check("busy_serve", 32'(busy), 32'd1);
    if (ack !== 1'b1) wait_ack();
    grant = 4'b0000;
    if (push_in_ack) push = g;
    tick();
    push = 4'b0000;
  endtask

  task automatic reset_async_check();
    #3 reset = 1'b0;
    #1;
    check("async_reset_outputs", 32'({req, ack, served, full, overflow, busy}), 32'd0);
    tick();
    reset = 1'b1;
  endtask

  initial begin
    // Reset and idle.
    tick();
    tick();
    check("reset_outputs", 32'({req, ack, served, full, overflow, busy}), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_outputs", 32'({req, ack, full, overflow, busy}), 32'd0);
    end

    // Single request, single service.
    push = 4'b0010;
    tick();
    push = 4'b0000;
    check("req_single", 32'(req), 32'h2);
    serve(4'b0010, 1'b0);
    check("req_after_ack", 32'(req), 32'h0);

    // Saturation and overflow, then drain.
    for (int i = 0; i < 8; i++) begin
      push = 4'b0001;
      tick();
      if (i == 6) begin
        check("full_at_7", 32'(full), 32'h1);
        check("ovf_before_8", 32'(overflow), 32'd0);
      end
    end
    push = 4'b0000;
    check("ovf_after_8", 32'(overflow), 32'd1);
    check("full_after_8", 32'(full), 32'h1);
    for (int i = 0; i < 7; i++) begin
      serve(4'b0001, 1'b0);
      if (i == 0) check("full_drop", 32'(full), 32'h0);
    end
    check("req_drained", 32'(req), 32'h0);
    check("ovf_sticky", 32'(overflow), 32'd1);

    // Async reset clears sticky overflow.
    reset_async_check();
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Push to the client being acked nets to zero change.
    push = 4'b0100;
    tick();
    push = 4'b0000;
    serve(4'b0100, 1'b1);
    check("req_push_in_ack", 32'(req), 32'h4);
    check("ovf_push_in_ack", 32'(overflow), 32'd0);
    serve(4'b0100, 1'b0);
    check("req_after_second", 32'(req), 32'h0);

    // Illegal grants in IDLE.
    push = 4'b0101;
    tick();
    push = 4'b0000;
    check("req_0101", 32'(req), 32'h5);
    grant = 4'b0011;
    tick();
    check("busy_multihot", 32'(busy), 32'd0);
`ifdef RR_GRANT_CHECK_EN
    check("gerr_multihot", 32'(grant_err), 32'd1);
`endif
    grant = 4'b0010;
    tick();
    check("busy_nonreq", 32'(busy), 32'd0);
`ifdef RR_GRANT_CHECK_EN
    check("gerr_nonreq", 32'(grant_err), 32'd1);
`endif
    grant = 4'b0000;
    tick();
`ifdef RR_GRANT_CHECK_EN
    check("gerr_clear", 32'(grant_err), 32'd0);
`endif
    check("req_unchanged", 32'(req), 32'h5);

    // Grant switched during SERVE: captured client wins, client 2 needs a fresh grant.
    begin
      exp_t e;
      grant    = 4'b0001;
      e.served = 4'b0001;
      e.cyc    = cyc + 1 + SERVICE_LEN;
      sb.push_back(e);
      tick();
      check("busy_switch", 32'(busy), 32'd1);
      grant = 4'b0100;
      wait_ack();
      e.served = 4'b0100;
      e.cyc    = cyc + 2 + SERVICE_LEN;
      sb.push_back(e);
      tick();
      wait_ack();
      grant = 4'b0000;
      tick();
      check("req_after_switch", 32'(req), 32'h0);
    end

    // Reset during SERVE: no ack, counts lost.
    push = 4'b1010;
    tick();
    push  = 4'b0000;
    grant = 4'b1000;
    tick();
    check("busy_before_reset", 32'(busy), 32'd1);
    grant = 4'b0000;
    reset_async_check();
    for (int i = 0; i < 6; i++) tick();
    check("req_after_reset", 32'(req), 32'h0);
    check("busy_after_reset", 32'(busy), 32'd0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rr_request_agent.md
Name: rr_request_agent

Overview:
- Requester-side companion to the round-robin arbiter's rotating priority pointer.
- Collects per-client request pulses into saturating pending counters and presents a request vector to the arbiter.
- Accepts the arbiter's one-hot grant, runs a fixed-length service window, then returns a one-cycle ack. The arbiter uses that ack to rotate its priority pointer.
- Pulses served back to the granted client.

Parameters:
- WIDTH, 4, number of clients (width of req/grant vectors).
- CNT_W, 3, pending-counter width per client; saturates at 2^CNT_W-1 (7).
- SERVICE_LEN, 2, service-window length in cycles; legal range 1..255.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- push  in  WIDTH  bit i high for one cycle = client i enqueues one request
- req  out  WIDTH  bit i = 1 while pending count i > 0
- grant  in  WIDTH  one-hot grant from arbiter
- ack  out  1  one-cycle pulse; grant consumed, arbiter may rotate pointer
- served  out  WIDTH  one-cycle pulse on bit of serviced client, coincident with ack
- full  out  WIDTH  bit i = 1 while count i is saturated
- overflow  out  1  sticky; set when push hits a full counter
- busy  out  1  high in SERVE and ACK states

Behaviour:
- Reset (async, active-low): all counts 0, state IDLE. req, ack, served, full, overflow and busy all 0. Internal grant register is 0.
- req, full and busy are registered-state decodes, with no combinational path from push or grant. ack and served are registered.
- Per-client count_i, next-state rules:
  - push_i and not dec_i: +1, unless saturated. At saturation hold and set overflow.
  - dec_i and not push_i: -1.
  - Both: unchanged, even when full; overflow is not set.
  - dec_i is high only in ACK state for the captured client.
- State machine:
  - IDLE: grant is legal when exactly one bit is set and that bit's req is 1. On a legal grant, capture it into grant_q, load the service counter with SERVICE_LEN-1, and go to SERVE. Illegal grants (zero, multi-hot, or to a non-requesting client) are ignored and the state stays IDLE.
  - SERVE: grant input is ignored. Decrement the service counter; when it reads 0, go to ACK.
  - ACK: ack=1 and served=grant_q for exactly this cycle; decrement the captured count. Then return to IDLE, and the next grant is sampled the following cycle.
- Latency: legal grant sampled at edge t → ack high during cycle t+SERVICE_LEN+1 (first cycle after ACK entry). Minimum grant-to-grant spacing is SERVICE_LEN+2 cycles.
- Arbiter contract: the arbiter must hold grant stable until it sees ack. Grant changes during SERVE do not affect grant_q.
- Push to the client currently being served is legal. The count nets per the rules above, and req for that client stays high if count remains > 0 after ACK.
- Reset mid-SERVE/ACK: immediate return to reset values. No ack is issued and pending requests are lost.
- overflow clears only on reset.

Optional Feature:
- RR_GRANT_CHECK_EN defined: adds output grant_err (1 bit, reset 0), a registered one-cycle pulse whenever the IDLE state sees a non-zero illegal grant (multi-hot, or to a non-requesting client).
- Not defined: port absent, illegal grants silently ignored, no extra logic.
- Functional behaviour of all other ports is identical in both builds.

Decomposition:
- Package rr_pkg:
  - state encoding constants (IDLE=2'd0, SERVE=2'd1, ACK=2'd2)
  - service counter width (8)
  - one-hot check function used by both this block and the arbiter
- Sub-module rr_pending_counter: one per client (generate loop). Saturating up/down counter with push, dec, count, nonzero, full, and ovf_pulse outputs.
- Top level contains the FSM, service counter, and overflow OR-reduction/sticky register.

Test Plan:
- Reset then idle, push=0 → req=0, ack=0, full=0, overflow=0 for 10 cycles; async assertion mid-clock zeroes outputs without a clock edge.
- push=4'b0010 once, grant=4'b0010 held, SERVICE_LEN=2 → ack and served=4'b0010 exactly 3 cycles after grant sampled; req[1] drops the next cycle.
- push[0] pulsed 8 times, CNT_W=3 → full[0]=1 after the 7th push, overflow=1 after the 8th; then 7 grant/ack rounds return count to 0 and req[0]=0. overflow stays 1.
- Client 2 has count 1 and is in ACK while push[2]=1 → count stays 1, req[2] stays 1, overflow unchanged.
- In IDLE with req=4'b0101: grant=4'b0011 then 4'b0010 → no state change, no ack; with RR_GRANT_CHECK_EN, grant_err pulses once per illegal cycle.
- Grant switches 4'b0001→4'b0100 during SERVE → served=4'b0001; client 2 is served only after a fresh grant in IDLE. Reset asserted in SERVE → no ack, all counts 0.
